// File: rtl/ahb_decoder_pkg.sv
// Shared AHB-Lite encodings and helpers for the address decoder and its default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DSEL_NONE = 2'd0,
        DSEL_RAM  = 2'd1,
        DSEL_ROM  = 2'd2
    } dsel_t;

    typedef enum logic [1:0] {
        DFLT_IDLE = 2'd0,
        DFLT_ERR1 = 2'd1,
        DFLT_ERR2 = 2'd2
    } dflt_state_t;

    // Unsigned offset compare also rejects addresses below base (they wrap high).
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (off < size);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ahb_decoder_if.sv
// Bus-side signals between the AHB-Lite master, ahb_mux and the address decoder.
interface ahb_decoder_if;

    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready_mux;
    logic        hresp_mux;
    logic        hsel_inst;
    logic        hsel_data;
    logic        muxsel;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, htrans, hready_mux, hresp_mux,
        input  hsel_inst, hsel_data, muxsel, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hready_mux, hresp_mux,
        output hsel_inst, hsel_data, muxsel, hready, hresp
    );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response plus error capture.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        accept_unmapped,
    input  logic [31:0] haddr,
    output logic        hready_dflt,
    output logic        hresp_dflt,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    dflt_state_t state_q;
    logic        hready_q;
    logic        hresp_q;
    logic [31:0] err_addr_q;
    logic [7:0]  err_count_q;

    // accept_unmapped can only be high in IDLE or ERR2, where the slave drives hready=1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= DFLT_IDLE;
            hready_q    <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                DFLT_IDLE: begin
                    if (accept_unmapped) begin
                        state_q  <= DFLT_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end
                end
                DFLT_ERR1: begin
                    state_q  <= DFLT_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                DFLT_ERR2: begin
                    if (accept_unmapped) begin
                        state_q  <= DFLT_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end else begin
                        state_q  <= DFLT_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q  <= DFLT_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase

            if (accept_unmapped) begin
                err_addr_q  <= haddr;
                err_count_q <= sat_inc8(err_count_q);
            end
        end
    end

    assign hready_dflt = hready_q;
    assign hresp_dflt  = hresp_q;
    assign err_addr    = err_addr_q;
    assign err_count   = err_count_q;

endmodule

// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder: ROM/RAM selects, data-phase owner register and final
// hready/hresp mux including the default slave.
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_SIZE = 32'h0000_8000,
    parameter logic [31:0] RAM_BASE = 32'h2000_0000,
    parameter logic [31:0] RAM_SIZE = 32'h0001_0000
) (
    input  logic         clk,
    input  logic         n_rst,
    ahb_decoder_if.slave bus,
    output logic [31:0]  err_addr,
    output logic [7:0]   err_count
);

    logic  rom_hit;
    logic  ram_hit;
    logic  trans_valid;
    logic  accept;
    logic  accept_unmapped;
    logic  hready_dflt;
    logic  hresp_dflt;
    dsel_t dsel_q;
    dsel_t dsel_d;

    assign rom_hit     = in_region(bus.haddr, ROM_BASE, ROM_SIZE);
    assign ram_hit     = in_region(bus.haddr, RAM_BASE, RAM_SIZE) & ~rom_hit;
    assign trans_valid = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);

    assign bus.hsel_inst = rom_hit;
    assign bus.hsel_data = ram_hit;

    // Final hready doubles as the address-acceptance strobe.
    assign accept          = bus.hready;
    assign accept_unmapped = accept & trans_valid & ~rom_hit & ~ram_hit;

    always_comb begin
        dsel_d = dsel_q;
        if (accept) begin
            if (rom_hit)      dsel_d = DSEL_ROM;
            else if (ram_hit) dsel_d = DSEL_RAM;
            else              dsel_d = DSEL_NONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) dsel_q <= DSEL_NONE;
        else        dsel_q <= dsel_d;
    end

    assign bus.muxsel = (dsel_q == DSEL_ROM);

    // The only combinational path from ahb_mux is this pass-through.
    assign bus.hready = (dsel_q == DSEL_NONE) ? hready_dflt : bus.hready_mux;
    assign bus.hresp  = (dsel_q == DSEL_NONE) ? hresp_dflt  : bus.hresp_mux;

    ahb_default_slave u_dflt (
        .clk             (clk),
        .n_rst           (n_rst),
        .accept_unmapped (accept_unmapped),
        .haddr           (bus.haddr),
        .hready_dflt     (hready_dflt),
        .hresp_dflt      (hresp_dflt),
        .err_addr        (err_addr),
        .err_count       (err_count)
    );

endmodule

// File: tb/tb_ahb_decoder.sv
// Directed self-checking bench for ahb_decoder.
module tb_ahb_decoder;
    import ahb_pkg::*;

    logic        clk;
    logic        n_rst;
    logic [31:0] err_addr;
    logic [7:0]  err_count;
    int          nchk;
    int          nerr;

    ahb_decoder_if bus ();

    ahb_decoder dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        bus.haddr  = a;
        bus.htrans = t;
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.hready_mux = 1'b1;
        bus.hresp_mux  = 1'b0;
        drive(32'h0, HTRANS_IDLE);
        #10;
        nchk++; if (bus.hready !== 1'b1) begin nerr++; $display("FAIL rst_hready got=%b exp=1", bus.hready); end
        nchk++; if (bus.hresp !== 1'b0) begin nerr++; $display("FAIL rst_hresp got=%b exp=0", bus.hresp); end
        nchk++; if (bus.muxsel !== 1'b0) begin nerr++; $display("FAIL rst_muxsel got=%b exp=0", bus.muxsel); end
        nchk++; if (err_addr !== 32'h0) begin nerr++; $display("FAIL rst_err_addr got=%h exp=0", err_addr); end
        n_rst = 1'b1;
        cyc();
        drive(32'h4000_0000, HTRANS_NONSEQ);
        cyc();
        nchk++; if (bus.hready !== 1'b0 || err_count !== 8'd1) begin nerr++; $display("FAIL pre_rst_err1 hready=%b count=%0d exp 0/1", bus.hready, err_count); end
        #2;
        n_rst = 1'b0;
        #1;
        nchk++; if (bus.hready !== 1'b1) begin nerr++; $display("FAIL midrst_hready got=%b exp=1", bus.hready); end
        nchk++; if (bus.hresp !== 1'b0) begin nerr++; $display("FAIL midrst_hresp got=%b exp=0", bus.hresp); end
        nchk++; if (bus.muxsel !== 1'b0) begin nerr++; $display("FAIL midrst_muxsel got=%b exp=0", bus.muxsel); end
        nchk++; if (err_count !== 8'd0) begin nerr++; $display("FAIL midrst_count got=%0d exp=0", err_count); end
        drive(32'h0, HTRANS_IDLE);
        #1;
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic test_rom_ram();
        drive(32'h0000_0010, HTRANS_NONSEQ);
        nchk++; if (bus.hsel_inst !== 1'b1 || bus.hsel_data !== 1'b0) begin nerr++; $display("FAIL rom_hsel inst=%b data=%b exp 1/0", bus.hsel_inst, bus.hsel_data); end
        cyc();
        drive(32'h2000_0004, HTRANS_NONSEQ);
        nchk++; if (bus.hsel_inst !== 1'b0 || bus.hsel_data !== 1'b1) begin nerr++; $display("FAIL ram_hsel inst=%b data=%b exp 0/1", bus.hsel_inst, bus.hsel_data); end
        nchk++; if (bus.muxsel !== 1'b1) begin nerr++; $display("FAIL rom_dphase_muxsel got=%b exp=1", bus.muxsel); end
        bus.hresp_mux = 1'b1;
        #1;
        nchk++; if (bus.hresp !== 1'b1) begin nerr++; $display("FAIL rom_hresp_pass got=%b exp=1", bus.hresp); end
        bus.hresp_mux = 1'b0;
        cyc();
        drive(32'h2000_0000, HTRANS_IDLE);
        nchk++; if (bus.muxsel !== 1'b0) begin nerr++; $display("FAIL ram_dphase_muxsel got=%b exp=0", bus.muxsel); end
        cyc();
    endtask

    task automatic test_wait_state();
        drive(32'h0000_0100, HTRANS_NONSEQ);
        cyc();
        bus.hready_mux = 1'b0;
        drive(32'h2000_0008, HTRANS_NONSEQ);
        for (int i = 0; i < 3; i++) begin
            nchk++; if (bus.muxsel !== 1'b1 || bus.hready !== 1'b0) begin nerr++; $display("FAIL wait_hold%0d muxsel=%b hready=%b exp 1/0", i, bus.muxsel, bus.hready); end
            cyc();
        end
        bus.hready_mux = 1'b1;
        #1;
        nchk++; if (bus.muxsel !== 1'b1) begin nerr++; $display("FAIL wait_release muxsel got=%b exp=1", bus.muxsel); end
        cyc();
        drive(32'h2000_0000, HTRANS_IDLE);
        nchk++; if (bus.muxsel !== 1'b0) begin nerr++; $display("FAIL wait_after muxsel got=%b exp=0", bus.muxsel); end
        cyc();
    endtask

    task automatic test_unmapped();
        drive(32'h4000_0000, HTRANS_NONSEQ);
        nchk++; if (bus.hsel_inst !== 1'b0 || bus.hsel_data !== 1'b0) begin nerr++; $display("FAIL unm_hsel inst=%b data=%b exp 0/0", bus.hsel_inst, bus.hsel_data); end
        cyc();
        drive(32'h4000_0000, HTRANS_IDLE);
        nchk++; if (bus.hready !== 1'b0 || bus.hresp !== 1'b1) begin nerr++; $display("FAIL unm_err1 hready=%b hresp=%b exp 0/1", bus.hready, bus.hresp); end
        cyc();
        nchk++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b1) begin nerr++; $display("FAIL unm_err2 hready=%b hresp=%b exp 1/1", bus.hready, bus.hresp); end
        nchk++; if (err_addr !== 32'h4000_0000) begin nerr++; $display("FAIL unm_err_addr got=%h exp=40000000", err_addr); end
        nchk++; if (err_count !== 8'd1) begin nerr++; $display("FAIL unm_count got=%0d exp=1", err_count); end
        cyc();
        nchk++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin nerr++; $display("FAIL unm_idle_okay hready=%b hresp=%b exp 1/0", bus.hready, bus.hresp); end
        cyc();
        nchk++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0 || err_count !== 8'd1) begin nerr++; $display("FAIL unm_idle_again hready=%b hresp=%b count=%0d exp 1/0/1", bus.hready, bus.hresp, err_count); end
    endtask

    task automatic test_boundaries();
        drive(32'h0000_7FFC, HTRANS_NONSEQ);
        nchk++; if (bus.hsel_inst !== 1'b1) begin nerr++; $display("FAIL bnd_rom_top hsel_inst got=%b exp=1", bus.hsel_inst); end
        cyc();
        drive(32'h0000_8000, HTRANS_NONSEQ);
        nchk++; if (bus.muxsel !== 1'b1 || bus.hready !== 1'b1) begin nerr++; $display("FAIL bnd_rom_dphase muxsel=%b hready=%b exp 1/1", bus.muxsel, bus.hready); end
        nchk++; if (bus.hsel_inst !== 1'b0 || bus.hsel_data !== 1'b0) begin nerr++; $display("FAIL bnd_rom_end hsel inst=%b data=%b exp 0/0", bus.hsel_inst, bus.hsel_data); end
        cyc();
        drive(32'h2000_FFFC, HTRANS_IDLE);
        nchk++; if (bus.hready !== 1'b0 || bus.hresp !== 1'b1 || err_addr !== 32'h0000_8000) begin nerr++; $display("FAIL bnd_rom_end_err hready=%b hresp=%b addr=%h exp 0/1/00008000", bus.hready, bus.hresp, err_addr); end
        cyc();
        drive(32'h2000_FFFC, HTRANS_NONSEQ);
        nchk++; if (bus.hsel_data !== 1'b1 || bus.hsel_inst !== 1'b0) begin nerr++; $display("FAIL bnd_ram_top hsel inst=%b data=%b exp 0/1", bus.hsel_inst, bus.hsel_data); end
        cyc();
        drive(32'h2001_0000, HTRANS_NONSEQ);
        nchk++; if (bus.muxsel !== 1'b0 || bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin nerr++; $display("FAIL bnd_ram_dphase muxsel=%b hready=%b hresp=%b exp 0/1/0", bus.muxsel, bus.hready, bus.hresp); end
        nchk++; if (bus.hsel_inst !== 1'b0 || bus.hsel_data !== 1'b0) begin nerr++; $display("FAIL bnd_ram_end hsel inst=%b data=%b exp 0/0", bus.hsel_inst, bus.hsel_data); end
        cyc();
        drive(32'h0, HTRANS_IDLE);
        nchk++; if (bus.hready !== 1'b0 || bus.hresp !== 1'b1 || err_count !== 8'd3) begin nerr++; $display("FAIL bnd_ram_end_err hready=%b hresp=%b count=%0d exp 0/1/3", bus.hready, bus.hresp, err_count); end
        cyc();
        cyc();
    endtask

    task automatic test_back_to_back();
        drive(32'h5000_0000, HTRANS_NONSEQ);
        cyc();
        drive(32'h5000_0004, HTRANS_NONSEQ);
        cyc();
        nchk++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b1) begin nerr++; $display("FAIL b2b_err2 hready=%b hresp=%b exp 1/1", bus.hready, bus.hresp); end
        cyc();
        nchk++; if (bus.hready !== 1'b0 || bus.hresp !== 1'b1) begin nerr++; $display("FAIL b2b_err1_again hready=%b hresp=%b exp 0/1", bus.hready, bus.hresp); end
        nchk++; if (err_addr !== 32'h5000_0004 || err_count !== 8'd5) begin nerr++; $display("FAIL b2b_capture addr=%h count=%0d exp 50000004/5", err_addr, err_count); end
        for (int i = 0; i < 600; i++) cyc();
        drive(32'h0, HTRANS_IDLE);
        cyc();
        cyc();
        cyc();
        nchk++; if (err_count !== 8'd255) begin nerr++; $display("FAIL sat_count got=%0d exp=255", err_count); end
        nchk++; if (bus.hready !== 1'b1 || bus.hresp !== 1'b0) begin nerr++; $display("FAIL sat_idle hready=%b hresp=%b exp 1/0", bus.hready, bus.hresp); end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        test_reset();
        test_rom_ram();
        test_wait_state();
        test_unmapped();
        test_boundaries();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ahb_decoder.md
# ahb_decoder

Address-phase decoder and data-phase select register for the SoC's single-master AHB-Lite bus. It drives `hsel_inst` and `hsel_data` to the ROM and RAM slaves, and registers which slave owns the current data phase. That register drives `muxsel` into `ahb_mux`. The block also takes the muxed `hready`/`hresp` back from `ahb_mux`, contains the default slave for unmapped addresses, and drives the final `hready`/`hresp` seen by the master and both slaves.

## Interface
- `ROM_BASE`, default 32'h0000_0000: ROM region base; aligned to `ROM_SIZE`.
- `ROM_SIZE`, default 32'h0000_8000: ROM region size in bytes; power of two.
- `RAM_BASE`, default 32'h2000_0000: RAM region base; aligned to `RAM_SIZE`.
- `RAM_SIZE`, default 32'h0001_0000: RAM region size in bytes; power of two.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; one clock, reset asynchronous and active-low.
- `haddr`  in  32  master address.
- `htrans`  in  2  master transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hready_mux`  in  1  `hready` from `ahb_mux`.
- `hresp_mux`  in  1  `hresp` from `ahb_mux`.
- `hsel_inst`  out  1  ROM select.
- `hsel_data`  out  1  RAM select.
- `muxsel`  out  1  to `ahb_mux`: 1 selects ROM, 0 selects RAM.
- `hready`  out  1  final bus ready.
- `hresp`  out  1  final bus response: 0 OKAY, 1 ERROR.
- `err_addr`  out  32  address of the most recent unmapped valid transfer.
- `err_count`  out  8  count of unmapped valid transfers; saturates at 255.

## Operation
- **Decode**
  - Combinational, from `haddr` only; `htrans` is not used.
  - ROM hit when `haddr - ROM_BASE < ROM_SIZE` (unsigned). RAM hit by the same rule.
  - ROM wins if the regions overlap. `hsel_inst`/`hsel_data` are one-hot or both 0.
- **Valid transfer**: `htrans[1] == 1` (NONSEQ or SEQ).
- **Address acceptance**: an address phase is accepted on a rising edge with final `hready == 1`. At acceptance, register `dsel`:
  - ROM on a ROM hit;
  - RAM on a RAM hit;
  - NONE otherwise.
- **`muxsel`**: equals `dsel == ROM`. It is 0 for RAM and for NONE.
- **Final `hready`/`hresp`**
  - `dsel` ROM or RAM: pass `hready_mux`/`hresp_mux` through.
  - `dsel` NONE: the default slave drives them.
- **Default slave FSM**, states IDLE, ERR1, ERR2:
  - IDLE: `hready=1`, `hresp=0`. An accepted valid unmapped transfer goes to ERR1; anything else stays in IDLE.
  - ERR1: `hready=0`, `hresp=1`. Always goes to ERR2.
  - ERR2: `hready=1`, `hresp=1`. Acceptance happens here. The next state is ERR1 if the accepted transfer is valid and unmapped, otherwise IDLE.
  - An accepted unmapped IDLE/BUSY transfer gives `dsel=NONE` with the FSM in IDLE, i.e. a zero-wait OKAY.
- **Error capture**: on each accepted valid unmapped transfer:
  - `err_addr <= haddr`;
  - `err_count` increments and holds at 8'hFF.
- **Reset values**
  - State: FSM IDLE, `dsel` NONE, `err_addr` 0, `err_count` 0.
  - Outputs: `muxsel=0`, `hready=1`, `hresp=0`. `hsel_*` are combinational from `haddr`.
- **Reset mid-error**: asynchronous return to IDLE/NONE. `hready` goes to 1 immediately.

## Timing
- `hsel_*`: 0-cycle combinational from `haddr`.
- `muxsel`: valid from the cycle after acceptance and held for the whole data phase, including wait states. It changes only on an edge with `hready=1`.
- Unmapped valid transfer accepted at edge N:
  - cycle N+1: `hready=0`, `hresp=1`;
  - cycle N+2: `hready=1`, `hresp=1`.
  - Total: exactly 2 cycles, per AHB-Lite two-cycle ERROR.
- No combinational path from `hready_mux`/`hresp_mux` to `muxsel` or `hsel_*`. The only such path is pass-through to `hready`/`hresp`.
- Slave wait states (`hready_mux=0`) freeze `dsel`, the FSM and the error capture registers.

## Structure
- **Package `ahb_pkg`**:
  - `htrans` localparams: `HTRANS_IDLE`, `HTRANS_BUSY`, `HTRANS_NONSEQ`, `HTRANS_SEQ`.
  - `dsel_t` enum: `DSEL_NONE`, `DSEL_RAM`, `DSEL_ROM`.
  - `dflt_state_t` enum: `DFLT_IDLE`, `DFLT_ERR1`, `DFLT_ERR2`.
  - `HRESP_OKAY`/`HRESP_ERROR` constants.
- **Sub-module `ahb_default_slave`**:
  - Contains the FSM, `err_addr` and `err_count`.
  - Inputs: `clk`, `n_rst`, `accept_unmapped`, `haddr`.
  - Outputs: `hready_dflt`, `hresp_dflt`, `err_addr`, `err_count`.
- **Top level**: decode, `dsel` register and the output mux.

## Test plan
- **Reset**: assert `n_rst`=0 mid-ERR1 → same cycle `hready=1`, `hresp=0`, `muxsel=0`, `err_count=0`.
- **ROM then RAM back-to-back**: NONSEQ 0x0000_0010 then NONSEQ 0x2000_0004, `hready_mux=1` → `hsel_inst` then `hsel_data`; `muxsel` 1 in the first data phase, 0 in the second.
- **Wait state hold**: ROM read with `hready_mux=0` for 3 cycles while `haddr` switches to RAM → `muxsel` stays 1 throughout; goes to 0 only after the edge where `hready_mux=1`.
- **Unmapped access**: NONSEQ 0x4000_0000 → `hready`/`hresp` = 0/1 then 1/1; `err_addr=0x4000_0000`, `err_count=1`. IDLE to the same address → OKAY zero-wait, count unchanged.
- **Back-to-back errors**: unmapped NONSEQ accepted in ERR2 → ERR1 again. 300 errors → `err_count=255`.
- **Boundaries**: 0x0000_7FFC is ROM; 0x0000_8000 is unmapped (error); 0x2000_FFFC is RAM; 0x2001_0000 is unmapped.
